// File: rtl/f2_sched_pkg.sv
// Shared state encoding and sizing helpers for the f2 array scheduler.
// Beat counts are derived here so the top and the bench agree on node geometry.
package f2_sched_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic int ilog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Index of the final beat; nodes narrower than one beat still take one beat.
    function automatic int beat_last(input int len, input int log2p);
        return (len >= log2p) ? (1 << (len - log2p)) - 1 : 0;
    endfunction

endpackage

// File: rtl/f2_sched_pipe.sv
// Read-latency delay line: carries beat valid and beat index so write-back
// and array enable line up with belief-memory read data.
module f2_sched_pipe
    import f2_sched_pkg::*;
#(
    parameter int AW     = 6,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_vld,
    input  logic [AW-1:0] rd_k,
    input  logic [AW-1:0] base_d,
    output logic          wr_en,
    output logic          f2_en,
    output logic [AW-1:0] wr_addr,
    output logic          drain_last
);

    // Every stage except the output one; when these are empty the current write is the last.
    localparam logic [RD_LAT-1:0] HEAD_MASK = {RD_LAT{1'b1}} >> 1;

    logic [RD_LAT-1:0] vld_p;
    logic [AW-1:0]     k_p [RD_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= rd_vld;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        k_p[0] <= rd_k;
        for (int i = 1; i < RD_LAT; i++) begin
            k_p[i] <= k_p[i-1];
        end
    end

    assign wr_en      = vld_p[RD_LAT-1];
    assign f2_en      = wr_en;
    assign wr_addr    = wr_en ? base_d + k_p[RD_LAT-1] : '0;
    assign drain_last = ~|(vld_p & HEAD_MASK);

endmodule

// File: rtl/f2_array_sched.sv
// Beat sequencer for the P-lane f2 (d = min(a,b)+c) array: issues operand
// reads, then aligned write-backs of d, and pulses done after the last write.
module f2_array_sched
    import f2_sched_pkg::*;
#(
    parameter int Q      = 10,
    parameter int P      = 16,
    parameter int N      = 1024,
    parameter int AW     = 6,
    parameter int LW     = 4,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] len_log2,
    input  logic [AW-1:0] base_a,
    input  logic [AW-1:0] base_b,
    input  logic [AW-1:0] base_c,
    input  logic [AW-1:0] base_d,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    output logic [AW-1:0] rd_addr_c,
    output logic          f2_en,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [P-1:0]  lane_mask
);

    localparam int            LOG2N   = ilog2(N);
    localparam int            LOG2P   = ilog2(P);
    localparam logic [LW-1:0] LEN_MAX = LW'(LOG2N);

    if (Q < 1 || RD_LAT < 1 || RD_LAT > 3 || (1 << AW) != N / P) begin : g_bad_cfg
        $error("f2_array_sched: unsupported parameter combination");
    end

    function automatic logic [P-1:0] lane_mask_f(input logic [LW-1:0] len);
        logic [P-1:0] m;
        m = '0;
        for (int i = 0; i < P; i++) begin
            m[i] = (len >= LW'(LOG2P)) || (i < (1 << len));
        end
        return m;
    endfunction

    logic [1:0]    state_q;
    logic [AW-1:0] k_q;
    logic [AW-1:0] last_q;
    logic [AW-1:0] base_a_q, base_b_q, base_c_q, base_d_q;
    logic [P-1:0]  mask_q;
    logic          err_q;
    logic          len_ok;
    logic          accept;
    logic          drain_last;

    assign len_ok = (len_log2 <= LEN_MAX);
    assign accept = (state_q == ST_IDLE) && start && len_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= (state_q == ST_IDLE) && start && !len_ok;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_ISSUE;
                        k_q     <= '0;
                    end
                end
                ST_ISSUE: begin
                    k_q <= k_q + 1'b1;
                    if (k_q == last_q) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drain_last) state_q <= ST_DONE;
                end
                ST_DONE:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // Job descriptor is held for the whole job; outputs are gated so reset values never leak out.
    always_ff @(posedge clk) begin
        if (accept) begin
            base_a_q <= base_a;
            base_b_q <= base_b;
            base_c_q <= base_c;
            base_d_q <= base_d;
            last_q   <= AW'(beat_last(int'(len_log2), LOG2P));
            mask_q   <= lane_mask_f(len_log2);
        end
    end

    assign busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign rd_en     = (state_q == ST_ISSUE);
    assign rd_addr_a = rd_en ? base_a_q + k_q : '0;
    assign rd_addr_b = rd_en ? base_b_q + k_q : '0;
    assign rd_addr_c = rd_en ? base_c_q + k_q : '0;
    assign lane_mask = wr_en ? mask_q : '0;

    f2_sched_pipe #(
        .AW     (AW),
        .RD_LAT (RD_LAT)
    ) u_pipe (
        .clk        (clk),
        .rst        (rst),
        .rd_vld     (rd_en),
        .rd_k       (k_q),
        .base_d     (base_d_q),
        .wr_en      (wr_en),
        .f2_en      (f2_en),
        .wr_addr    (wr_addr),
        .drain_last (drain_last)
    );

endmodule

// File: doc/f2_array_sched.md
Name: f2_array_sched

Overview:
- Multi-cycle sequencer for the P-lane f2 (d = min(a,b)+c) datapath in the SCAN decoder.
- Accepts one node-update job: node length 2^len_log2 LLRs, base addresses of operands a/b/c and result d.
- Walks the node in P-lane beats: issues belief-memory reads, gates the array enable in step with read data, issues aligned write-backs, signals completion.
- Sits between the SCAN stage controller and the belief-memory/f2 array pair.

Parameters:
- Q, 10, LLR width per lane (pass-through only, for lane-mask sizing consistency).
- P, 16, lanes per beat.
- N, 1024, code length.
- AW, 6, beat-address width = log2(N/P).
- LW, 4, width of len_log2 = ceil(log2(log2(N)+1)).
- RD_LAT, 1, belief-memory read latency in cycles (1..3).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request, sampled only in IDLE.
- len_log2  in  LW  log2 of node length (0..log2(N)).
- base_a, base_b, base_c, base_d  in  AW each  beat base addresses.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse after last write.
- err  out  1  one-cycle pulse for rejected job.
- rd_en  out  1  read strobe.
- rd_addr_a, rd_addr_b, rd_addr_c  out  AW each  read beat addresses.
- f2_en  out  1  drives the array enable.
- wr_en  out  1  write strobe for d.
- wr_addr  out  AW  write beat address.
- lane_mask  out  P  valid lanes of current write beat.

Behaviour:
- Reset (async): state IDLE; busy, done, err, rd_en, f2_en, wr_en = 0; addresses 0; lane_mask 0; pipeline valid bits cleared. Reset mid-job aborts with no further writes and no done.
- Beats B = 2^len_log2 / P if 2^len_log2 >= P, else B = 1.
- lane_mask = all ones when 2^len_log2 >= P; otherwise low 2^len_log2 bits set.
- States:
  - IDLE: start=1 and len_log2 <= log2(N) -> latch job, beat counter k = 0, go ISSUE, busy=1 next cycle.
  - IDLE: start=1 and len_log2 > log2(N) -> err pulse next cycle, stay IDLE.
  - ISSUE: rd_en=1; rd_addr_x = base_x + k (mod 2^AW, wrap-around allowed); k++. Go DRAIN after issuing k = B-1.
  - DRAIN: wait until the read pipeline is empty, then go DONE.
  - DONE: done=1 for one cycle, busy=0 from this cycle, then IDLE.
- Write path: shift register of depth RD_LAT carries valid and k.
  - At RD_LAT cycles after each read: f2_en=1, wr_en=1, wr_addr = base_d + k (mod 2^AW), lane_mask as above. The array is combinational, so d is valid the same cycle.
- Timing: start sampled at edge 0; reads at cycles 1..B; writes at 1+RD_LAT..B+RD_LAT; done at B+RD_LAT+1; busy high cycles 1..B+RD_LAT.
- start while busy or in DONE: ignored, no queuing.
- Next job may start in the cycle after done (the IDLE cycle); start in the same cycle as done is ignored.
- f2_en=0 whenever wr_en=0, so the array outputs zeros.
- Operand address ranges may overlap the d range; no hazard check. Reads of beat k precede its write.

Decomposition:
- Shared package f2_sched_pkg: state encoding (IDLE, ISSUE, DRAIN, DONE), derived constants LOG2N = log2(N) and LOG2P = log2(P), beat-count function.
- One sub-module: f2_sched_pipe, a RD_LAT-deep valid/address delay line producing wr_en, f2_en and wr_addr.

Test Plan:
- P=16, RD_LAT=1, len_log2=6, bases a=0, b=4, c=8, d=12: 4 reads at 0..3/4..7/8..11 in cycles 1..4; writes at 12..15 in cycles 2..5; lane_mask=16'hFFFF; done at cycle 6.
- len_log2=2: B=1, lane_mask=16'h000F; single write at base_d; done at cycle 3.
- len_log2=10, base_a=60: B=64; rd_addr_a wraps 63 -> 0; exactly 64 wr_en pulses; done at cycle 66.
- len_log2=11: err pulse at cycle 1; busy, rd_en and wr_en stay 0.
- start asserted every cycle during a B=4 job: only one job runs. The retrigger while done=1 is ignored; the next job begins from the following IDLE cycle.
- rst asserted at cycle 3 of a B=4 job with RD_LAT=2: all outputs 0 immediately; no done; a new start after reset runs normally.
